// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generation unit.
package pc_pkg;

  // Next-PC source selected by the priority mux
  typedef enum logic [2:0] {
    SEL_SEQ = 3'd0,
    SEL_BR  = 3'd1,
    SEL_J   = 3'd2,
    SEL_JR  = 3'd3,
    SEL_RAS = 3'd4,
    SEL_EXC = 3'd5
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int          INSTR_BYTES_DEF = 32'sd4;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/control inputs and PC/RAS status outputs of the PC generator.
interface pc_gen_if #(
  parameter int ADDR_W = 32,
  parameter int JIDX_W = 26
);
  logic              stall_i;
  logic              exc_valid_i;
  logic [ADDR_W-1:0] exc_vector_i;
  logic              br_taken_i;
  logic [ADDR_W-1:0] br_imm_i;
  logic              j_valid_i;
  logic [JIDX_W-1:0] j_idx_i;
  logic              jr_valid_i;
  logic [ADDR_W-1:0] jr_target_i;
  logic              call_i;
  logic              ret_i;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pc_plus_o;
  logic              ras_empty_o;
  logic              ras_full_o;
  logic              ras_miss_o;

  // Fetch/decode control side: drives redirects, observes the PC
  modport master (
    output stall_i, exc_valid_i, exc_vector_i, br_taken_i, br_imm_i,
           j_valid_i, j_idx_i, jr_valid_i, jr_target_i, call_i, ret_i,
    input  pc_o, pc_plus_o, ras_empty_o, ras_full_o, ras_miss_o
  );

  // PC generator side
  modport slave (
    input  stall_i, exc_valid_i, exc_vector_i, br_taken_i, br_imm_i,
           j_valid_i, j_idx_i, jr_valid_i, jr_target_i, call_i, ret_i,
    output pc_o, pc_plus_o, ras_empty_o, ras_full_o, ras_miss_o
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; a pop on an empty stack is ignored. Push and pop together
// replace the top entry in place (on an empty stack it acts as a push only).
module pc_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_d, ptr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [PTR_W-1:0]  ptr_inc_s, ptr_dec_s;
  logic              empty_s, full_s;

  assign ptr_inc_s = ptr_q + PTR_W'(1);
  assign ptr_dec_s = ptr_q - PTR_W'(1);
  assign empty_s   = (cnt_q == CNT_W'(0));
  assign full_s    = (cnt_q == CNT_W'(RAS_DEPTH));

  // Next stack state from the push/pop request
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i && pop_i && !empty_s) begin
      mem_d[ptr_q] = data_i;
    end else if (push_i) begin
      ptr_d            = ptr_inc_s;
      mem_d[ptr_inc_s] = data_i;
      if (full_s) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_s) begin
      ptr_d = ptr_dec_s;
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stack storage, top pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign top_o   = mem_q[ptr_q];
  assign empty_o = empty_s;
  assign full_o  = full_s;
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: registered PC, target
// arithmetic, priority next-PC mux, stall/exception handling and RAS control.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int                IMM_SHIFT   = 2,
  parameter int                JIDX_W      = 26,
  parameter int                RAS_DEPTH   = 4
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave io
);
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] pc_plus_s, br_off_s, br_tgt_s, j_tgt_s, ras_top_s, nxt_tgt_s;
  logic              miss_d, miss_q;
  logic              redir_ok_s, push_s, pop_s;
  logic              ras_empty_s, ras_full_s;
  pc_sel_e           sel_s;

  // Target arithmetic; all sums wrap silently modulo 2^ADDR_W
  assign pc_plus_s = pc_q + ADDR_W'(INSTR_BYTES);
  assign br_off_s  = io.br_imm_i << IMM_SHIFT;
  assign br_tgt_s  = pc_plus_s + br_off_s;
  assign j_tgt_s   = {pc_plus_s[ADDR_W-1:JIDX_W+IMM_SHIFT], io.j_idx_i, {IMM_SHIFT{1'b0}}};

  // Priority selection of the next-PC source
  always_comb begin
    sel_s = SEL_SEQ;
    if (io.exc_valid_i) begin
      sel_s = SEL_EXC;
    end else if (io.jr_valid_i) begin
      if (io.ret_i && !ras_empty_s) begin
        sel_s = SEL_RAS;
      end else begin
        sel_s = SEL_JR;
      end
    end else if (io.j_valid_i) begin
      sel_s = SEL_J;
    end else if (io.br_taken_i) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux; a stall holds the PC unless an exception redirects it
  always_comb begin
    nxt_tgt_s = pc_plus_s;
    case (sel_s)
      SEL_SEQ: nxt_tgt_s = pc_plus_s;
      SEL_BR:  nxt_tgt_s = br_tgt_s;
      SEL_J:   nxt_tgt_s = j_tgt_s;
      SEL_JR:  nxt_tgt_s = io.jr_target_i;
      SEL_RAS: nxt_tgt_s = ras_top_s;
      SEL_EXC: nxt_tgt_s = io.exc_vector_i;
      default: nxt_tgt_s = pc_plus_s;
    endcase
    if (io.stall_i && !io.exc_valid_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = nxt_tgt_s;
    end
  end

  // RAS requests only on cycles that actually advance without an exception
  always_comb begin
    redir_ok_s = !io.stall_i && !io.exc_valid_i;
    push_s     = redir_ok_s && io.call_i && (io.j_valid_i || io.jr_valid_i);
    pop_s      = redir_ok_s && io.ret_i && io.jr_valid_i;
    miss_d     = pop_s && ras_empty_s;
  end

  // PC and return-miss pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= miss_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (pc_plus_s),
    .top_o   (ras_top_s),
    .empty_o (ras_empty_s),
    .full_o  (ras_full_s)
  );

  assign io.pc_o        = pc_q;
  assign io.pc_plus_o   = pc_plus_s;
  assign io.ras_empty_o = ras_empty_s;
  assign io.ras_full_o  = ras_full_s;
  assign io.ras_miss_o  = miss_q;
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generation unit for the fetch stage.
- Holds the registered PC and computes the next PC from four sources: sequential increment, PC-relative branch, pseudo-direct jump, and register jump.
- Adds a small circular return-address stack (RAS) for call/return prediction, plus stall and exception redirect.
- Replaces the standalone +4 and branch-target adders. Fetch and link-register writeback consume its outputs.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (ADDR_W bits).
- INSTR_BYTES, 4, sequential increment in bytes.
- IMM_SHIFT, 2, left shift applied to branch immediate and jump index.
- JIDX_W, 26, width of jump instruction index field.
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC and RAS this cycle
- exc_valid_i  in  1  exception redirect request
- exc_vector_i  in  ADDR_W  exception handler address
- br_taken_i  in  1  taken conditional branch
- br_imm_i  in  ADDR_W  sign-extended branch immediate (word offset)
- j_valid_i  in  1  pseudo-direct jump
- j_idx_i  in  JIDX_W  jump instruction index
- jr_valid_i  in  1  register jump
- jr_target_i  in  ADDR_W  register jump target
- call_i  in  1  current redirect is a call; push link address
- ret_i  in  1  register jump is a return; target from RAS
- pc_o  out  ADDR_W  current PC (registered)
- pc_plus_o  out  ADDR_W  pc_o + INSTR_BYTES (combinational, also link address)
- ras_empty_o  out  1  RAS count == 0
- ras_full_o  out  1  RAS count == RAS_DEPTH
- ras_miss_o  out  1  registered one-cycle pulse: return taken with empty RAS

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - pc_o=RESET_PC, RAS count=0, top pointer=0.
  - ras_miss_o=0, ras_empty_o=1, ras_full_o=0.
  - RAS entry contents are don't-care.
- Latency: inputs are sampled on the rising edge and the new PC is visible on pc_o the next cycle. pc_plus_o follows pc_o combinationally.
- Arithmetic: all sums are mod 2^ADDR_W; wrap-around is silent.
  - Sequential target = pc_o + INSTR_BYTES.
  - Branch target = pc_plus_o + (br_imm_i << IMM_SHIFT), with the shift truncated to ADDR_W.
  - Jump target = {pc_plus_o[ADDR_W-1 : JIDX_W+IMM_SHIFT], j_idx_i, IMM_SHIFT zeros}.
- Next-PC priority, highest first:
  1. exc_valid_i.
  2. jr_valid_i: with ret_i, target = RAS top if non-empty, else jr_target_i.
  3. j_valid_i.
  4. br_taken_i.
  5. Sequential.
- Stall:
  - stall_i=1 holds pc_o and all RAS state; ras_miss_o=0.
  - Exception overrides stall: pc_o loads exc_vector_i.
  - RAS is untouched on an exception cycle, and call/ret are ignored.
- RAS push/pop only when not stalled and no exception:
  - Push requires call_i with j_valid_i or jr_valid_i (the selected source is a jump). Pushed value = pc_plus_o.
  - Pop requires ret_i with jr_valid_i.
  - call_i/ret_i without the corresponding valid: ignored.
  - Pop on empty: no state change; next cycle ras_miss_o=1 for one cycle; target falls back to jr_target_i.
  - Push on full: overwrite oldest entry (circular). Top advances; count stays RAS_DEPTH.
  - Simultaneous pop+push (call_i, ret_i, jr_valid_i all 1): target = old top. The top entry is replaced with pc_plus_o; count unchanged. If the RAS was empty: push only (count=1) and miss pulse.
- Pointers wrap modulo RAS_DEPTH.
- Reset asserted mid-operation: immediately returns to reset values regardless of pending redirects.

Decomposition:
- Shared package pc_pkg:
  - next-PC select enum (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_RAS, SEL_EXC).
  - default RESET_PC and INSTR_BYTES constants.
- One sub-module: pc_ras, a circular stack with push, pop, top, count, empty, full, parametrised by ADDR_W and RAS_DEPTH.
- Target arithmetic and priority mux stay in pc_gen.

Test Plan:
- Reset then 3 idle cycles -> pc_o 0x0, 0x4, 0x8, 0xC; pc_plus_o always pc_o+4.
- At pc 0x100: br_taken_i=1, br_imm_i=0xFFFF_FFFE -> next pc 0x0FC. Same cycle with j_valid_i=1, j_idx_i=0x40 -> jump wins, pc 0x100.
- At pc 0x200: call via j_valid_i (idx 0x400 -> pc 0x1000). Then at 0x1000: ret_i+jr_valid_i with jr_target_i=0xDEAD -> pc 0x204; ras_empty_o=1 after.
- 5 calls with RAS_DEPTH=4 -> ras_full_o=1 with oldest link lost. 4 returns yield links 5,4,3,2 in order. The 5th return uses jr_target_i and pulses ras_miss_o.
- stall_i=1 for 3 cycles with br_taken_i=1 -> pc_o held. exc_valid_i=1, exc_vector_i=0x80 during the stall -> pc 0x80 next cycle, RAS count unchanged.
- rst_n driven low mid-cycle while j_valid_i=1 -> pc_o=RESET_PC immediately (before the clock edge); RAS empty; ras_miss_o=0.
